// File: rtl/mem_req_arbiter_pkg.sv
// Shared constants for the memory request arbiter: FSM encoding, size/owner codes,
// kseg segment selectors and the latched bus request record.
package mem_req_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [3:0] SEG_KSEG0_LO = 4'h8;
  localparam logic [3:0] SEG_KSEG0_HI = 4'h9;
  localparam logic [3:0] SEG_KSEG1_LO = 4'hA;
  localparam logic [3:0] SEG_KSEG1_HI = 4'hB;

  typedef struct packed {
    logic        owner;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        uncache;
  } bus_cmd_t;

endpackage

// File: rtl/mem_req_arbiter_addr_xlate.sv
// Fixed kseg virtual-to-physical mapping; kseg1 is flagged uncached.
module addr_xlate
  import mem_req_arbiter_pkg::*;
(
  input  logic [31:0] va,
  output logic [31:0] pa,
  output logic        uncache
);

  always_comb begin
    pa      = va;
    uncache = 1'b0;
    case (va[31:28])
      SEG_KSEG1_LO, SEG_KSEG1_HI: begin
        pa      = {3'b000, va[28:0]};
        uncache = 1'b1;
      end
      SEG_KSEG0_LO, SEG_KSEG0_HI: pa = {1'b0, va[30:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Single-outstanding arbiter sharing the memory bus between fetch and data ports.
// Data has priority; a saturating counter forces a fetch grant after STARVE_MAX data wins.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_uncache,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  bus_cmd_t         cmd_q, cmd_d;

  logic        grant_inst;
  logic [31:0] va_mux, pa_mux;
  logic        unc_mux;

  assign grant_inst = inst_req && (!data_req || (starve_cnt_q == CNT_MAX));
  assign va_mux     = grant_inst ? inst_addr : data_addr;

  addr_xlate u_xlate (
    .va      (va_mux),
    .pa      (pa_mux),
    .uncache (unc_mux)
  );

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    cmd_d        = cmd_q;
    case (state_q)
      ST_IDLE: begin
        if (inst_req || data_req) begin
          cmd_d.owner   = grant_inst ? OWN_INST : OWN_DATA;
          cmd_d.wr      = grant_inst ? 1'b0 : data_wr;
          cmd_d.size    = grant_inst ? SIZE_WORD : data_size;
          cmd_d.wstrb   = grant_inst ? 4'b0000 : data_wstrb;
          cmd_d.addr    = pa_mux;
          cmd_d.wdata   = grant_inst ? 32'h0 : data_wdata;
          cmd_d.uncache = unc_mux;
          state_d       = ST_REQ;
          if (grant_inst)
            starve_cnt_d = '0;
          else if (inst_req && (starve_cnt_q != CNT_MAX))
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
      end
      ST_REQ:  if (bus_addr_ok) state_d = ST_WAIT;
      ST_WAIT: if (bus_data_ok) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= '0;
      cmd_q        <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      cmd_q        <= cmd_d;
    end
  end

  assign bus_req     = (state_q == ST_REQ);
  assign bus_wr      = cmd_q.wr;
  assign bus_size    = cmd_q.size;
  assign bus_wstrb   = cmd_q.wstrb;
  assign bus_addr    = cmd_q.addr;
  assign bus_wdata   = cmd_q.wdata;
  assign bus_uncache = cmd_q.uncache;

  // Handshake pulses are combinational so the requester sees acceptance in the bus cycle itself.
  assign inst_addr_ok = bus_req && bus_addr_ok && (cmd_q.owner == OWN_INST);
  assign data_addr_ok = bus_req && bus_addr_ok && (cmd_q.owner == OWN_DATA);
  assign inst_data_ok = (state_q == ST_WAIT) && bus_data_ok && (cmd_q.owner == OWN_INST);
  assign data_data_ok = (state_q == ST_WAIT) && bus_data_ok && (cmd_q.owner == OWN_DATA);
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: translation, priority, starvation and reset cases.
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr, bus_uncache;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_uncache(bus_uncache),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one transaction starting in an IDLE window with the requests already driven.
  // drop: 0 keep requests, 1 drop the owner's request after acceptance, 2 drop both.
  task automatic txn(input string tag, input bit exp_inst, input logic [31:0] exp_addr,
                     input logic exp_unc, input logic exp_wr, input logic [1:0] exp_size,
                     input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                     input logic [31:0] rdata, input int drop);
    tick;
    chk({tag, ".bus_req"}, 32'(bus_req), 32'd1);
    chk({tag, ".bus_addr"}, bus_addr, exp_addr);
    chk({tag, ".uncache"}, 32'(bus_uncache), 32'(exp_unc));
    chk({tag, ".wr"}, 32'(bus_wr), 32'(exp_wr));
    chk({tag, ".size"}, 32'(bus_size), 32'(exp_size));
    chk({tag, ".wstrb"}, 32'(bus_wstrb), 32'(exp_wstrb));
    if (!exp_inst) chk({tag, ".wdata"}, bus_wdata, exp_wdata);
    bus_addr_ok = 1'b1;
    #1;
    chk({tag, ".inst_addr_ok"}, 32'(inst_addr_ok), 32'(exp_inst));
    chk({tag, ".data_addr_ok"}, 32'(data_addr_ok), 32'(!exp_inst));
    tick;
    bus_addr_ok = 1'b0;
    if (drop == 2) begin
      inst_req = 1'b0;
      data_req = 1'b0;
    end else if (drop == 1) begin
      if (exp_inst) inst_req = 1'b0;
      else          data_req = 1'b0;
    end
    chk({tag, ".wait_no_req"}, 32'(bus_req), 32'd0);
    bus_data_ok = 1'b1;
    bus_rdata   = rdata;
    #1;
    chk({tag, ".inst_data_ok"}, 32'(inst_data_ok), 32'(exp_inst));
    chk({tag, ".data_data_ok"}, 32'(data_data_ok), 32'(!exp_inst));
    chk({tag, ".rdata"}, exp_inst ? inst_rdata : data_rdata, rdata);
    tick;
    bus_data_ok = 1'b0;
    #1;
  endtask

  task automatic set_data(input logic wr, input logic [1:0] size, input logic [3:0] wstrb,
                          input logic [31:0] addr, input logic [31:0] wdata);
    data_req   = 1'b1;
    data_wr    = wr;
    data_size  = size;
    data_wstrb = wstrb;
    data_addr  = addr;
    data_wdata = wdata;
  endtask

  initial begin
    reset = 1'b1;
    inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_wstrb = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    tick; tick;
    chk("rst.bus_req", 32'(bus_req), 32'd0);
    chk("rst.bus_addr", bus_addr, 32'h0);
    chk("rst.bus_wr", 32'(bus_wr), 32'd0);
    chk("rst.oks", {28'h0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'h0);
    reset = 1'b0;
    tick;

    // kseg1 fetch; bus_req must still be low in the cycle the request appears
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    #1;
    chk("kseg1_inst.req_latency", 32'(bus_req), 32'd0);
    txn("kseg1_inst", 1'b1, 32'h1FC0_0000, 1'b1, 1'b0, 2'd2, 4'h0, 32'h0, 32'h3C08_BFC0, 1);

    set_data(1'b1, 2'd1, 4'b0011, 32'h8000_1234, 32'hDEAD_BEEF);
    txn("kseg0_wr", 1'b0, 32'h0000_1234, 1'b0, 1'b1, 2'd1, 4'b0011, 32'hDEAD_BEEF, 32'h0, 1);

    set_data(1'b0, 2'd2, 4'h0, 32'h0040_0010, 32'h0);
    txn("kuseg_rd", 1'b0, 32'h0040_0010, 1'b0, 1'b0, 2'd2, 4'h0, 32'h0, 32'h1111_2222, 1);
    set_data(1'b0, 2'd0, 4'h0, 32'hA000_0010, 32'h0);
    txn("kseg1_rd", 1'b0, 32'h0000_0010, 1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0000_00AB, 1);
    set_data(1'b0, 2'd2, 4'h0, 32'h9FC0_0004, 32'h0);
    txn("kseg0_hi_rd", 1'b0, 32'h1FC0_0004, 1'b0, 1'b0, 2'd2, 4'h0, 32'h0, 32'h5555_AAAA, 1);
    set_data(1'b1, 2'd2, 4'hF, 32'hC000_0000, 32'h0BAD_F00D);
    txn("kseg2_wr", 1'b0, 32'hC000_0000, 1'b0, 1'b1, 2'd2, 4'hF, 32'h0BAD_F00D, 32'h0, 1);

    // simultaneous requests: data first, inst on the following IDLE
    inst_req = 1'b1; inst_addr = 32'hBFC0_0010;
    set_data(1'b0, 2'd2, 4'h0, 32'h8000_0100, 32'h0);
    txn("both.data_first", 1'b0, 32'h0000_0100, 1'b0, 1'b0, 2'd2, 4'h0, 32'h0, 32'h1234_5678, 1);
    txn("both.inst_next", 1'b1, 32'h1FC0_0010, 1'b1, 1'b0, 2'd2, 4'h0, 32'h0, 32'h8765_4321, 1);

    // starvation: both held, 4 data grants then a forced inst grant
    inst_req = 1'b1; inst_addr = 32'h8000_0200;
    set_data(1'b0, 2'd2, 4'h0, 32'hA000_0300, 32'h0);
    for (int i = 0; i < 4; i++)
      txn($sformatf("starve.data%0d", i), 1'b0, 32'h0000_0300, 1'b1, 1'b0, 2'd2, 4'h0, 32'h0,
          32'h100 + 32'(i), 0);
    txn("starve.inst", 1'b1, 32'h0000_0200, 1'b0, 1'b0, 2'd2, 4'h0, 32'h0, 32'hCAFE_0001, 1);
    // counter cleared: data wins again with inst pending
    inst_req = 1'b1;
    txn("starve.cleared", 1'b0, 32'h0000_0300, 1'b1, 1'b0, 2'd2, 4'h0, 32'h0, 32'h200, 2);

    // spurious bus_data_ok in REQ and bus_addr_ok in WAIT are ignored
    set_data(1'b0, 2'd2, 4'h0, 32'h8000_0400, 32'h0);
    tick;
    bus_data_ok = 1'b1; bus_rdata = 32'hBAD0_BAD0;
    #1;
    chk("spur.no_data_ok", 32'(data_data_ok), 32'd0);
    tick;
    bus_data_ok = 1'b0;
    chk("spur.still_req", 32'(bus_req), 32'd1);
    bus_addr_ok = 1'b1;
    #1;
    chk("spur.addr_ok", 32'(data_addr_ok), 32'd1);
    tick;
    bus_addr_ok = 1'b1; data_req = 1'b0;
    #1;
    chk("spur.wait_addr_ok", 32'(data_addr_ok), 32'd0);
    tick;
    bus_addr_ok = 1'b0;
    chk("spur.wait_held", 32'(bus_req), 32'd0);
    bus_data_ok = 1'b1; bus_rdata = 32'h600D_DA7A;
    #1;
    chk("spur.data_ok", 32'(data_data_ok), 32'd1);
    chk("spur.rdata", data_rdata, 32'h600D_DA7A);
    tick;
    bus_data_ok = 1'b0;

    // reset in WAIT abandons the transaction
    set_data(1'b0, 2'd2, 4'h0, 32'h8000_0500, 32'h0);
    tick;
    bus_addr_ok = 1'b1;
    #1;
    tick;
    bus_addr_ok = 1'b0; data_req = 1'b0;
    reset = 1'b1;
    #1;
    chk("rstwait.bus_req", 32'(bus_req), 32'd0);
    tick;
    reset = 1'b0;
    tick;
    bus_data_ok = 1'b1;
    #1;
    chk("rstwait.no_data_ok", {30'h0, inst_data_ok, data_data_ok}, 32'h0);
    tick;
    bus_data_ok = 1'b0;
    chk("rstwait.idle", 32'(bus_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
